pixel_alu_pipe: RTL and testbench



---
 rtl/pixel_alu_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_pixel_alu_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_alu_pipe.sv
// pixel_alu_pipe: two-stage valid/ready pixel point-operation unit.
// Each pixel carries its own operation select, contrast gain, threshold and
// brightness offset; S1 captures the request and S2 registers the result.
// Optional build macro PIX_ALU_STATS_EN adds stats_clr, pix_count and
// sat_count (saturating output-handshake and saturation counters).

module pixel_alu_pipe #(
    parameter int unsigned CH_W      = 4,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned GAIN_W    = 6,
    parameter int unsigned GAIN_FRAC = 2,
    parameter int unsigned MAP_CH    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CH_W-1:0]   in_pixel,
    input  logic [2:0]               in_func,
    input  logic [GAIN_W-1:0]        in_gain,
    input  logic [CH_W-1:0]          in_thresh,
    input  logic [CH_W:0]            in_offset,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   out_pixel
`ifdef PIX_ALU_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [31:0]              pix_count,
    output logic [31:0]              sat_count
`endif
);

    localparam int unsigned PIX_W = NUM_CH * CH_W;
    localparam int unsigned MAX   = (2 ** CH_W) - 1;
    localparam int unsigned MID   = 2 ** (CH_W - 1);
    // Signed working width for contrast and brightness before clamping.
    localparam int unsigned CW    = CH_W + GAIN_W + 2;

    typedef enum logic [2:0] {
        OP_INVERT   = 3'b000,
        OP_PSEUDO   = 3'b001,
        OP_CONTRAST = 3'b010,
        OP_THRESH   = 3'b011,
        OP_BRIGHT   = 3'b100,
        OP_PASS_5   = 3'b101,
        OP_PASS_6   = 3'b110,
        OP_PASS_7   = 3'b111
    } func_e;

    // Per-pixel request as captured by S1.
    typedef struct packed {
        logic [PIX_W-1:0]  pixel;
        func_e             func;
        logic [GAIN_W-1:0] gain;
        logic [CH_W-1:0]   thresh;
        logic [CH_W:0]     offset;
    } s1_req_t;

    logic             s1_valid;
    s1_req_t          s1_q;
    logic             s2_free;
    logic             in_fire;
    logic [PIX_W-1:0] res_pixel;
    logic [1:0]       pc_sel;

    // Pre-clamp contrast value: ((ch - MID) * gain) >>> GAIN_FRAC + MID.
    function automatic logic signed [CW-1:0] contrast_raw(
        input logic [CH_W-1:0]   ch,
        input logic [GAIN_W-1:0] gain
    );
        logic signed [CW-1:0] diff;
        logic signed [CW-1:0] prod;
        diff = $signed(CW'(ch)) - $signed(CW'(MID));
        prod = diff * $signed(CW'(gain));
        return (prod >>> GAIN_FRAC) + $signed(CW'(MID));
    endfunction

    // Pre-clamp brightness value: ch plus sign-extended offset.
    function automatic logic signed [CW-1:0] bright_raw(
        input logic [CH_W-1:0] ch,
        input logic [CH_W:0]   offset
    );
        return $signed(CW'(ch)) + $signed({{(CW - CH_W - 1){offset[CH_W]}}, offset});
    endfunction

    // Clamp a signed working value into [0, MAX].
    function automatic logic [CH_W-1:0] clamp_ch(input logic signed [CW-1:0] x);
        if (x[CW-1]) begin
            return '0;
        end else if (x > $signed(CW'(MAX))) begin
            return CH_W'(MAX);
        end else begin
            return x[CH_W-1:0];
        end
    endfunction

    // Per-channel result for every operation except pseudo-colour.
    function automatic logic [CH_W-1:0] chan_val(
        input logic [CH_W-1:0]   ch,
        input func_e             func,
        input logic [GAIN_W-1:0] gain,
        input logic [CH_W-1:0]   thresh,
        input logic [CH_W:0]     offset
    );
        logic [CH_W-1:0] v;
        case (func)
            OP_INVERT:   v = ~ch;
            OP_CONTRAST: v = clamp_ch(contrast_raw(ch, gain));
            OP_THRESH:   v = (ch > thresh) ? CH_W'(MAX) : '0;
            OP_BRIGHT:   v = clamp_ch(bright_raw(ch, offset));
            default:     v = ch;
        endcase
        return v;
    endfunction

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = in_valid && in_ready;

    // S1: capture pixel and its operation parameters on an input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_q.pixel  <= in_pixel;
                s1_q.func   <= func_e'(in_func);
                s1_q.gain   <= in_gain;
                s1_q.thresh <= in_thresh;
                s1_q.offset <= in_offset;
            end
        end
    end

    // Result datapath for the pixel held in S1.
    always_comb begin
        res_pixel = '0;
        pc_sel    = s1_q.pixel[MAP_CH*CH_W + CH_W - 1 -: 2];
        if (s1_q.func == OP_PSEUDO) begin
            case (pc_sel)
                2'b01:   res_pixel[0 +: CH_W]                 = CH_W'(MAX);
                2'b10:   res_pixel[CH_W +: CH_W]              = CH_W'(MAX);
                2'b11:   res_pixel[(NUM_CH-1)*CH_W +: CH_W]   = CH_W'(MAX);
                default: res_pixel                            = '0;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                res_pixel[c*CH_W +: CH_W] = chan_val(s1_q.pixel[c*CH_W +: CH_W], s1_q.func,
                                                     s1_q.gain, s1_q.thresh, s1_q.offset);
            end
        end
    end

    // S2: register the result; hold it while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pixel <= res_pixel;
            end
        end
    end

`ifdef PIX_ALU_STATS_EN
    localparam logic [31:0] CNT_MAX = '1;

    logic res_sat;
    logic out_sat;
    logic out_fire;

    // True when a signed working value falls outside [0, MAX].
    function automatic logic out_of_range(input logic signed [CW-1:0] x);
        return x[CW-1] || (x > $signed(CW'(MAX)));
    endfunction

    // Saturation flag: any channel out of range in contrast or brightness mode.
    always_comb begin
        res_sat = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s1_q.func == OP_CONTRAST) begin
                res_sat = res_sat | out_of_range(contrast_raw(s1_q.pixel[c*CH_W +: CH_W], s1_q.gain));
            end else if (s1_q.func == OP_BRIGHT) begin
                res_sat = res_sat | out_of_range(bright_raw(s1_q.pixel[c*CH_W +: CH_W], s1_q.offset));
            end
        end
    end

    // Saturation flag travels alongside out_pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
        end else if (s2_free && s1_valid) begin
            out_sat <= res_sat;
        end
    end

    assign out_fire = out_valid && out_ready;

    // Sticky-at-max counters; a synchronous clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count <= '0;
            sat_count <= '0;
        end else if (stats_clr) begin
            pix_count <= '0;
            sat_count <= '0;
        end else if (out_fire) begin
            if (pix_count != CNT_MAX) begin
                pix_count <= pix_count + 32'd1;
            end
            if (out_sat && (sat_count != CNT_MAX)) begin
                sat_count <= sat_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_alu_pipe.sv
// Bench for pixel_alu_pipe: reference model + queue scoreboard, directed
// cases with literal results, backpressure, reset and random streaming.

module tb_pixel_alu_pipe;

    localparam int CHW  = 4;
    localparam int NCH  = 3;
    localparam int MAXV = 15;
    localparam int MIDV = 8;
    localparam int GF   = 2;
    localparam int MCH  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_pixel = '0;
    logic [2:0]  in_func = '0;
    logic [5:0]  in_gain = '0;
    logic [3:0]  in_thresh = '0;
    logic [4:0]  in_offset = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_pixel;
`ifdef PIX_ALU_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] pix_count;
    logic [31:0] sat_count;
`endif

    pixel_alu_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .in_func   (in_func),
        .in_gain   (in_gain),
        .in_thresh (in_thresh),
        .in_offset (in_offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel)
`ifdef PIX_ALU_STATS_EN
        ,
        .stats_clr (stats_clr),
        .pix_count (pix_count),
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   prev_stall = 0;
    int   m_pix = 0;
    int   m_sat = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference behaviour from the operation rules, in plain integers.
    function automatic void model(input int pix, input int func, input int gain,
                                  input int thresh, input int off_raw,
                                  output int res, output bit sat);
        int off, sel, ch, v;
        off = (off_raw >= 16) ? off_raw - 32 : off_raw;
        res = 0;
        sat = 0;
        if (func == 1) begin
            sel = ((pix >> (MCH * CHW)) & MAXV) / (2 ** (CHW - 2));
            if (sel == 1)      res = MAXV;
            else if (sel == 2) res = MAXV << CHW;
            else if (sel == 3) res = MAXV << (CHW * (NCH - 1));
        end else begin
            for (int c = 0; c < NCH; c++) begin
                ch = (pix >> (c * CHW)) & MAXV;
                case (func)
                    0:       v = MAXV - ch;
                    2:       v = floor_div((ch - MIDV) * gain, 2 ** GF) + MIDV;
                    3:       v = (ch > thresh) ? MAXV : 0;
                    4:       v = ch + off;
                    default: v = ch;
                endcase
                if ((func == 2 || func == 4) && (v < 0 || v > MAXV)) sat = 1;
                if (v < 0) v = 0;
                if (v > MAXV) v = MAXV;
                res = res | (v << (c * CHW));
            end
        end
    endfunction

    // Scoreboard: compares every cycle against the in-flight queue.
    always @(negedge clk) begin
        exp_t e;
        int   r;
        bit   s;
        bit   hs;
        bit   hs_sat;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 0;
            m_pix = 0;
            m_sat = 0;
        end else begin
`ifdef PIX_ALU_STATS_EN
            check("pix_count", int'(pix_count), m_pix);
            check("sat_count", int'(sat_count), m_sat);
`endif
            check("in_ready_capacity", int'(in_ready), (exp_q.size() >= 2 && !out_ready) ? 0 : 1);
            if (prev_stall) check("hold_valid", int'(out_valid), 1);
            if (exp_q.size() >= 2) check("full_pipe_valid", int'(out_valid), 1);
            hs = 0;
            hs_sat = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual 0x%0h required none at %0t", out_pixel, $time);
                end else begin
                    check("out_pixel", int'(out_pixel), exp_q[0].pix);
                    if (out_ready) begin
                        hs = 1;
                        hs_sat = exp_q[0].sat;
                        void'(exp_q.pop_front());
                    end
                end
            end
`ifdef PIX_ALU_STATS_EN
            if (stats_clr) begin
                m_pix = 0;
                m_sat = 0;
            end else if (hs) begin
                m_pix++;
                if (hs_sat) m_sat++;
            end
`else
            if (hs) m_pix++;
            if (hs_sat) m_sat++;
`endif
            prev_stall = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                model(int'(in_pixel), int'(in_func), int'(in_gain), int'(in_thresh),
                      int'(in_offset), r, s);
                e.pix = r;
                e.sat = s;
                exp_q.push_back(e);
            end
        end
    end

    task automatic offer(input int pix, input int func, input int gain,
                         input int thresh, input int off);
        in_pixel  = 12'(pix);
        in_func   = 3'(func);
        in_gain   = 6'(gain);
        in_thresh = 4'(thresh);
        in_offset = 5'(off);
    endtask

    // Present one pixel and wait (bounded) for it to be accepted.
    task automatic send(input int pix, input int func, input int gain,
                        input int thresh, input int off);
        bit ok;
        @(posedge clk); #1;
        offer(pix, func, gain, thresh, off);
        in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input int req, output int lat);
        lat = 0;
        for (int t = 1; t <= 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = t;
                break;
            end
        end
        if (lat == 0) check({name, "_timeout"}, 0, 1);
        else check(name, int'(out_pixel), req);
    endtask

    task automatic run_dir(input string name, input int pix, input int func, input int gain,
                           input int thresh, input int off, input int req);
        int lat;
        send(pix, func, gain, thresh, off);
        expect_out(name, req, lat);
    endtask

    int bp_pix[4]  = '{'h3A5, 'h7A6, 'h0B0, 'h000};
    int bp_func[4] = '{0, 3, 1, 4};
    int bp_thr[4]  = '{0, 6, 0, 0};
    int bp_off[4]  = '{0, 0, 0, 15};
    int bp_exp[4]  = '{'hC5A, 'hFF0, 'h0F0, 'hFFF};

    initial begin
        int  r, lat, idx;
        bit  s, acc;

        // Pin the model with hand-computed results.
        model('hF18, 2, 6, 0, 0, r, s);
        check("model_contrast_px", r, 'hF08);
        check("model_contrast_sat", int'(s), 1);
        model('h8C4, 2, 6, 0, 0, r, s);
        check("model_contrast2_px", r, 'h8E2);
        check("model_contrast2_sat", int'(s), 0);
        model('h2F9, 4, 0, 0, 29, r, s);
        check("model_bright_px", r, 'h0C6);
        check("model_bright_sat", int'(s), 1);

        // Reset state.
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef PIX_ALU_STATS_EN
        check("rst_pix_count", int'(pix_count), 0);
`endif

        // Directed operations with out_ready high.
        send('h3A5, 0, 0, 0, 0);
        expect_out("invert", 'hC5A, lat);
        check("invert_latency", lat, 2);
        run_dir("contrast_a", 'h8C4, 2, 6, 0, 0, 'h8E2);
        run_dir("contrast_b", 'hF18, 2, 6, 0, 0, 'hF08);
        run_dir("threshold", 'h7A6, 3, 0, 6, 0, 'hFF0);
        run_dir("bright_neg", 'h2F9, 4, 0, 0, 29, 'h0C6);
        run_dir("bright_pos", 'h000, 4, 0, 0, 15, 'hFFF);
        run_dir("pseudo_b", 'h0B0, 1, 0, 0, 0, 'h0F0);
        run_dir("pseudo_5", 'h050, 1, 0, 0, 0, 'h00F);
        run_dir("pseudo_e", 'h0E0, 1, 0, 0, 0, 'hF00);
        run_dir("pseudo_2", 'h020, 1, 0, 0, 0, 'h000);
        run_dir("passthru", 'h123, 6, 9, 3, 7, 'h123);

        // Backpressure: four pixels offered while downstream stalls.
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        offer(bp_pix[0], bp_func[0], 0, bp_thr[0], bp_off[0]);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 5) begin
                check("bp_in_ready", int'(in_ready), 0);
                check("bp_accepts", idx, 2);
                check("bp_hold_valid", int'(out_valid), 1);
                check("bp_hold_pixel", int'(out_pixel), 'hC5A);
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) offer(bp_pix[idx], bp_func[idx], 0, bp_thr[idx], bp_off[idx]);
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            check("bp_drain_valid", int'(out_valid), 1);
            check("bp_drain_pixel", int'(out_pixel), bp_exp[k]);
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) offer(bp_pix[idx], bp_func[idx], 0, bp_thr[idx], bp_off[idx]);
                else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_empty_after", int'(out_valid), 0);

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send('h111, 0, 0, 0, 0);
        send('h222, 0, 0, 0, 0);
        check("full_before_rst", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        check("rst_async_pixel", int'(out_pixel), 0);
        check("rst_async_ready", int'(in_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("post_rst_no_stale", int'(out_valid), 0);
        end
`ifdef PIX_ALU_STATS_EN
        check("post_rst_pix_count", int'(pix_count), 0);

        // Clear coinciding with an output handshake.
        send('h0F0, 0, 0, 0, 0);
        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        check("clr_wins_pix_count", int'(pix_count), 0);
`endif

        // Random streaming with random backpressure.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    offer(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 31)));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef PIX_ALU_STATS_EN
            stats_clr = ($urandom_range(0, 63) == 0);
`endif
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (!acc) in_valid = in_valid;
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef PIX_ALU_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (6) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("drain_out_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
